// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sequencer
//  Description : Multi-cycle control unit for the 8-bit datapath. Fetches
//                instructions over a req/ack handshake, decodes them, runs
//                ADD/SUB/LI/JMP/HALT and drives the 4 x 8-bit register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [1:0] read_register1,
    output logic [1:0] read_register2,
    input  logic [7:0] read_data1,
    input  logic [7:0] read_data2,
    output logic [1:0] write_register,
    output logic [7:0] write_data,
    output logic       reg_write,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       halted,
    output logic [7:0] pc
);

    localparam logic [1:0] c_op_add   = 2'b00;
    localparam logic [1:0] c_op_sub   = 2'b01;
    localparam logic [1:0] c_op_li    = 2'b10;
    localparam logic [1:0] c_op_jmp   = 2'b11;
    localparam logic [7:0] c_halt_ins = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic       r_imem_req;
    logic       r_reg_write;
    logic       r_halted;

    logic       w_is_sub;
    logic [7:0] w_operand2;
    logic [8:0] w_sum;
    logic [7:0] w_li_imm;

    // Shared adder: SUB is rs + ~rt + 1, so bit 8 is the no-borrow flag.
    assign w_is_sub   = (r_ir[7:6] == c_op_sub);
    assign w_operand2 = w_is_sub ? ~read_data2 : read_data2;
    assign w_sum      = {1'b0, read_data1} + {1'b0, w_operand2} + {8'd0, w_is_sub};
    assign w_li_imm   = {4'b0000, r_ir[5:2]};

    assign imem_req       = r_imem_req;
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign read_register1 = r_ir[5:4];
    assign read_register2 = r_ir[3:2];
    assign write_register = r_ir[1:0];
    assign write_data     = r_result;
    assign reg_write      = r_reg_write;
    assign carry_flag     = r_carry;
    assign zero_flag      = r_zero;
    assign halted         = r_halted;

    // Sequencer FSM; request/strobe/halt outputs are registered on entry to their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= 8'h00;
            r_result    <= 8'h00;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_imem_req  <= 1'b0;
            r_reg_write <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir       <= imem_data;
                        r_pc       <= r_pc + 8'd1;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (r_ir == c_halt_ins) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else if (r_ir[7:6] == c_op_jmp) begin
                        r_pc       <= {2'b00, r_ir[5:0]};
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_ir[7:6] == c_op_li) begin
                        r_result <= w_li_imm;
                    end else if ((r_ir[7:6] == c_op_add) || (r_ir[7:6] == c_op_sub)) begin
                        r_result <= w_sum[7:0];
                        r_carry  <= w_sum[8];
                        r_zero   <= (w_sum[7:0] == 8'h00);
                    end
                    r_reg_write <= 1'b1;
                    r_state     <= ST_WB;
                end
                ST_WB: begin
                    r_reg_write <= 1'b0;
                    if (run) begin
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_imem_req  <= 1'b0;
                    r_reg_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_sequencer
//  Description : Self-checking bench for reg_file_sequencer with instruction
//                memory, register file and an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [1:0] read_register1, read_register2, write_register;
    logic [7:0] read_data1, read_data2, write_data;
    logic       reg_write, carry_flag, zero_flag, halted;
    logic [7:0] pc;

    reg_file_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .read_register1(read_register1), .read_register2(read_register2),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_register(write_register), .write_data(write_data), .reg_write(reg_write),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Environment: instruction memory, register file, observation logs
    logic [7:0] mem [256];
    logic [7:0] rf [4];
    logic [7:0] rf_init [4];
    logic       rf_load = 1'b0;
    logic [1:0] obs_reg [256];
    logic [7:0] obs_dat [256];
    int         wr_n = 0;
    logic [7:0] ack_addr [16];
    int         ack_cyc [16];
    int         ack_n = 0;
    int         rw_long = 0;
    logic       prev_rw = 1'b0;
    int         cyc = 0;

    // Responder controls
    int lat_cfg = 0;
    bit rand_lat = 1'b0;
    int spur_req = 0;
    int spur_done = 0;
    int wait_cnt = 0;
    int cur_lat = 0;

    assign read_data1 = rf[read_register1];
    assign read_data2 = rf[read_register2];

    // Register file writes and logging of writes / accepted fetches
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_load) begin
            rf      <= rf_init;
            wr_n    <= 0;
            ack_n   <= 0;
            rw_long <= 0;
            prev_rw <= 1'b0;
        end else begin
            prev_rw <= reg_write;
            if (reg_write && prev_rw) rw_long <= rw_long + 1;
            if (reg_write) begin
                rf[write_register] <= write_data;
                if (wr_n < 256) begin
                    obs_reg[wr_n] <= write_register;
                    obs_dat[wr_n] <= write_data;
                end
                wr_n <= wr_n + 1;
            end
            if (imem_ack && imem_req) begin
                if (ack_n < 16) begin
                    ack_addr[ack_n] <= imem_addr;
                    ack_cyc[ack_n]  <= cyc;
                end
                ack_n <= ack_n + 1;
            end
        end
    end

    // Memory responder: one-cycle ack after a configurable wait, plus spurious acks on request
    initial begin
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
                cur_lat  = lat_cfg;
            end else if (spur_req != spur_done) begin
                spur_done = spur_req;
                imem_ack  = 1'b1;
                imem_data = 8'hFF;
            end else if (imem_req) begin
                if (wait_cnt >= cur_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    wait_cnt  = 0;
                    cur_lat   = rand_lat ? int'($urandom_range(0, 2)) : lat_cfg;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        run     = 1'b0;
        rf_load = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        rf_load = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_halt"}, int'(ok), 1);
    endtask

    // Instruction-level reference model
    logic [1:0] exp_reg [64];
    logic [7:0] exp_dat [64];
    int         exp_n, exp_pc;
    int         exp_c, exp_z;

    task automatic run_model();
        logic [7:0] regs [4];
        logic [7:0] ins;
        int p, s, a, b, v;
        regs = rf_init;
        p = 0; exp_n = 0; exp_c = 0; exp_z = 0;
        for (int step = 0; step < 400; step++) begin
            ins = mem[p];
            p = (p + 1) % 256;
            if (ins == 8'hFF) break;
            a = int'(regs[ins[5:4]]);
            b = int'(regs[ins[3:2]]);
            if (ins[7:6] == 2'b11) begin
                p = int'(ins[5:0]);
                continue;
            end
            if (ins[7:6] == 2'b10) begin
                v = int'(ins[5:2]);
            end else if (ins[7:6] == 2'b00) begin
                s = a + b;
                v = s % 256;
                exp_c = (s > 255) ? 1 : 0;
                exp_z = (v == 0) ? 1 : 0;
            end else begin
                v = (a - b + 256) % 256;
                exp_c = (a >= b) ? 1 : 0;
                exp_z = (v == 0) ? 1 : 0;
            end
            regs[ins[1:0]] = 8'(v);
            if (exp_n < 64) begin
                exp_reg[exp_n] = ins[1:0];
                exp_dat[exp_n] = 8'(v);
            end
            exp_n++;
        end
        exp_pc = p;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] instr;
        logic [7:0] exp_val;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r;
        reset = 1'b1;
        run   = 1'b0;
        fill_mem(8'hFF);
        for (int i = 0; i < 4; i++) rf_init[i] = 8'h00;

        // r1 = a, r2 = b; 1B = ADD r3,r1,r2; 5B = SUB r3,r1,r2; BF = LI r3,#F
        vecs[0] = '{8'h05, 8'h03, 8'h1B, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h1B, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h80, 8'h90, 8'h1B, 8'h10, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h7F, 8'h1B, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h03, 8'h03, 8'h5B, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h02, 8'h05, 8'h5B, 8'hFD, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 8'h5B, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'hC8, 8'h37, 8'h5B, 8'h91, 1'b1, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 8'hBF, 8'h0F, 1'b0, 1'b0};

        // Reset state
        lat_cfg = 0;
        do_reset();
        chk("rst_pc", int'(pc), 0);
        chk("rst_req", int'(imem_req), 0);
        chk("rst_rw", int'(reg_write), 0);
        chk("rst_flags", int'({carry_flag, zero_flag, halted}), 0);
        chk("rst_wdata", int'(write_data), 0);

        // Table: single arithmetic / immediate instruction then HALT
        for (int t = 0; t < 9; t++) begin
            fill_mem(8'hFF);
            mem[0] = vecs[t].instr;
            rf_init[0] = 8'h00; rf_init[1] = vecs[t].a; rf_init[2] = vecs[t].b; rf_init[3] = 8'h00;
            do_reset();
            run = 1'b1;
            wait_halt("vec", 40);
            chk("vec_wr_n", wr_n, 1);
            chk("vec_wr_reg", int'(obs_reg[0]), 3);
            chk("vec_wr_dat", int'(obs_dat[0]), int'(vecs[t].exp_val));
            chk("vec_carry", int'(carry_flag), int'(vecs[t].exp_c));
            chk("vec_zero", int'(zero_flag), int'(vecs[t].exp_z));
            chk("vec_pc", int'(pc), 2);
        end

        // LI r1,#5 / LI r2,#3 / ADD r3 / HALT with zero-wait ack
        fill_mem(8'hFF);
        mem[0] = 8'h95; mem[1] = 8'h8E; mem[2] = 8'h1B;
        for (int i = 0; i < 4; i++) rf_init[i] = 8'h00;
        do_reset();
        run = 1'b1;
        wait_halt("prog", 60);
        chk("prog_wr_n", wr_n, 3);
        chk("prog_w0", int'({obs_reg[0], obs_dat[0]}), 'h105);
        chk("prog_w1", int'({obs_reg[1], obs_dat[1]}), 'h203);
        chk("prog_w2", int'({obs_reg[2], obs_dat[2]}), 'h308);
        chk("prog_flags", int'({carry_flag, zero_flag}), 0);
        chk("prog_pc", int'(pc), 4);
        chk("prog_cycles", ack_cyc[1] - ack_cyc[0], 4);
        chk("prog_cycles2", ack_cyc[3] - ack_cyc[2], 4);
        chk("prog_rw_width", rw_long, 0);

        // JMP 10 -> JMP 05 -> HALT: two-cycle jumps, no writes
        fill_mem(8'h00);
        mem[8'h00] = 8'hD0; mem[8'h10] = 8'hC5; mem[8'h05] = 8'hFF;
        do_reset();
        run = 1'b1;
        wait_halt("jmp", 40);
        chk("jmp_addr1", int'(ack_addr[1]), 'h10);
        chk("jmp_addr2", int'(ack_addr[2]), 'h05);
        chk("jmp_cycles", ack_cyc[1] - ack_cyc[0], 2);
        chk("jmp_cycles2", ack_cyc[2] - ack_cyc[1], 2);
        chk("jmp_no_write", wr_n, 0);
        chk("jmp_pc", int'(pc), 6);

        // Three-cycle ack delay, then a spurious ack during EXEC
        fill_mem(8'hFF);
        mem[0] = 8'h95;
        lat_cfg = 3;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dly_req_held", int'(imem_req), 1);
            chk("dly_ir_not_latched", int'(read_register1), 0);
        end
        @(negedge clk);
        chk("dly_req_drop", int'(imem_req), 0);
        chk("dly_ir_latched", int'(read_register1), 1);
        chk("dly_pc", int'(pc), 1);
        @(posedge clk);
        #1 spur_req++;
        @(negedge clk);
        @(negedge clk);
        chk("spur_wb_rw", int'(reg_write), 1);
        chk("spur_wb_data", int'({write_register, write_data}), 'h105);
        chk("spur_pc", int'(pc), 1);
        wait_halt("dly", 60);
        chk("dly_final_pc", int'(pc), 2);
        chk("dly_wr_n", wr_n, 1);
        lat_cfg = 0;

        // Reset during WB: strobe dropped, state and flags cleared
        fill_mem(8'hFF);
        mem[0] = 8'h00;
        for (int i = 0; i < 4; i++) rf_init[i] = 8'h00;
        do_reset();
        run = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (reg_write) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("rstwb_reached", int'(seen), 1);
        end
        chk("rstwb_zero_before", int'(zero_flag), 1);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        chk("rstwb_rw", int'(reg_write), 0);
        chk("rstwb_pc", int'(pc), 0);
        chk("rstwb_flags", int'({carry_flag, zero_flag, halted}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstwb_idle", int'(imem_req), 0);
        run = 1'b1;
        @(negedge clk);
        chk("rstwb_fetch", int'(imem_req), 1);

        // Reset during a pending fetch
        lat_cfg = 5;
        do_reset();
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstf_pending", int'(imem_req), 1);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        chk("rstf_abandon", int'(imem_req), 0);
        chk("rstf_pc", int'(pc), 0);
        reset = 1'b0;
        lat_cfg = 0;

        // PC wraps from FF to 00 on a non-jump fetch
        fill_mem(8'h80);
        mem[0] = 8'hFE;
        do_reset();
        run = 1'b1;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (pc == 8'hFF) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("wrap_reach_ff", int'(ok), 1);
            mem[0] = 8'hFF;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pc != 8'hFF) break;
            end
            chk("wrap_pc_00", int'(pc), 0);
        end
        wait_halt("wrap", 40);
        chk("wrap_final_pc", int'(pc), 1);

        // Random forward-flowing programs against the reference model
        rand_lat = 1'b1;
        for (int t = 0; t < 10; t++) begin
            fill_mem(8'hFF);
            k = int'($urandom_range(8, 30));
            for (int a = 0; a < k; a++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) mem[a] = 8'hC0 | 8'($urandom_range(a + 1, k));
                else mem[a] = {2'($urandom_range(0, 2)), 6'($urandom)};
            end
            for (int i = 0; i < 4; i++) rf_init[i] = 8'($urandom);
            run_model();
            do_reset();
            run = 1'b1;
            wait_halt("rnd", 600);
            chk("rnd_wr_n", wr_n, exp_n);
            for (int i = 0; i < exp_n && i < wr_n && i < 64; i++)
                chk("rnd_write", int'({obs_reg[i], obs_dat[i]}), int'({exp_reg[i], exp_dat[i]}));
            chk("rnd_carry", int'(carry_flag), exp_c);
            chk("rnd_zero", int'(zero_flag), exp_z);
            chk("rnd_pc", int'(pc), exp_pc);
            chk("rnd_rw_width", rw_long, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sequencer.md
# reg_file_sequencer

Multi-cycle control unit for the 8-bit datapath. It fetches 8-bit instructions over a req/ack memory handshake, decodes them, and drives the read/write ports of the 4 x 8-bit register file. Add/subtract results are computed internally and written back. It sits between instruction memory and the register file and owns the program counter, instruction register, result register and flags.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk edge.
- run  input  1  level; leaves IDLE when high.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  8  fetch address (= pc).
- imem_ack  input  1  one-cycle pulse; imem_data valid in the same cycle.
- imem_data  input  8  instruction byte.
- read_register1  output  2  register file read port 1 select (= ir[5:4]).
- read_register2  output  2  register file read port 2 select (= ir[3:2]).
- read_data1  input  8  register file read data 1, combinational from select.
- read_data2  input  8  register file read data 2.
- write_register  output  2  write select (= ir[1:0]).
- write_data  output  8  write data (= result register).
- reg_write  output  1  write strobe, exactly one clk cycle per writing instruction.
- carry_flag  output  1  carry out of ADD, or no-borrow of SUB.
- zero_flag  output  1  last ADD/SUB result == 0.
- halted  output  1  high in HALT state.
- pc  output  8  current program counter.

## Operation
- Instruction format: op = ir[7:6], rs = ir[5:4], rt = ir[3:2], rd = ir[1:0].
- Opcodes:
  - 00 ADD: rd <= rs + rt; carry = bit 8 of the 9-bit sum.
  - 01 SUB: rd <= rs - rt, computed as rs + ~rt + 1; carry = bit 8, i.e. 1 when rs >= rt.
  - 10 LI: rd <= {4'b0000, ir[5:2]}; flags unchanged.
  - 11 JMP: pc <= {2'b00, ir[5:0]}; no register write.
  - 8'hFF: HALT. Takes precedence over JMP.
- All arithmetic is 8-bit and wraps modulo 256.
- States:
  - IDLE: go to FETCH when run=1.
  - FETCH: imem_req=1; hold until imem_ack. On the ack cycle: ir <= imem_data, pc <= pc + 1 (wraps FF->00), go to DECODE.
  - DECODE: if ir=FF go to HALT; if op=11, pc <= target and go to FETCH; otherwise go to EXEC.
  - EXEC: result <= ALU(read_data1, read_data2) or the LI immediate; flags update for ADD/SUB only; go to WB.
  - WB: reg_write=1; go to FETCH if run=1, else IDLE.
  - HALT: halted=1; leave only by reset.
- imem_req stays high through FETCH until ack. An ack outside FETCH is ignored.
- Read selects are driven from ir continuously. write_register and write_data are stable throughout WB.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, ir=00, result=00, carry_flag=0, zero_flag=0, imem_req=0, reg_write=0, halted=0.
- Reset asserted in any state, including mid-fetch or during WB, wins on that edge:
  - the WB write strobe is dropped on the next cycle;
  - a pending fetch is abandoned.
- Cycle counts with zero-wait ack (ack in the first FETCH cycle):
  - ADD/SUB/LI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - JMP: 2 cycles.
  - Each extra ack wait adds 1 cycle.
- Flags become visible the cycle after EXEC.
- The register file sees write data one cycle after result is registered, so a back-to-back RAW dependency needs no stall.
- run deasserted mid-instruction does not stop it; the check happens only in WB, and in IDLE.

## Test plan
- Reset then run=1, memory {00:LI r1,#5 (8'h95), 01:LI r2,#3 (8'hA2? no -> 8'h8E), 02:ADD r3=r1+r2 (8'h1B), 03:FF}:
  - expected: reg_write pulses for r1=05, r2=03, r3=08;
  - carry=0, zero=0, halted=1, pc=04.
- SUB with r1=03, r2=03 (8'h5B into r3) -> r3=00, zero=1, carry=1.
- SUB with r1=02, r2=05 -> r3=FD, carry=0, zero=0.
- JMP 8'hC5 at address 10 -> next imem_addr=05, no reg_write pulse, 2-cycle instruction.
- imem_ack delayed 3 cycles -> imem_req held for 4 cycles, ir latched only on the ack cycle. An ack pulsed during EXEC is ignored.
- reset asserted during WB -> reg_write=0 on the next cycle, state=IDLE, pc=00, flags=0.
- pc at FF fetching a non-jump -> pc wraps to 00.
